// File: rtl/merger_4_feeder_if.sv
// Handshake bundle between the two sorted-list FIFOs, the feeder and the bitonic merge network.
// The master side is the feeder; the slave side is the FIFO/network environment.
interface merger_4_feeder_if #(
    parameter int unsigned DATA_WIDTH = 128
);
    localparam int unsigned BLK_W = 4 * DATA_WIDTH;

    logic [BLK_W-1:0] i_a_elems;
    logic             i_a_empty;
    logic             i_a_last;
    logic             o_a_rd;

    logic [BLK_W-1:0] i_b_elems;
    logic             i_b_empty;
    logic             i_b_last;
    logic             o_b_rd;

    logic             i_stall;
    logic [BLK_W-1:0] o_elems;
    logic             o_stall;
    logic             o_switch_output;
    logic             o_last;

    modport master (
        input  i_a_elems, i_a_empty, i_a_last,
        input  i_b_elems, i_b_empty, i_b_last,
        input  i_stall,
        output o_a_rd, o_b_rd,
        output o_elems, o_stall, o_switch_output, o_last
    );

    modport slave (
        output i_a_elems, i_a_empty, i_a_last,
        output i_b_elems, i_b_empty, i_b_last,
        output i_stall,
        input  o_a_rd, o_b_rd,
        input  o_elems, o_stall, o_switch_output, o_last
    );
endinterface

// File: rtl/merger_4_feeder.sv
// Selects the lower-keyed head block of two sorted FWFT lists each cycle and feeds it to the
// 8-input bitonic merge network; an all-ones flush block closes every merge pair.
module merger_4_feeder #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEY_WIDTH  = 80
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    merger_4_feeder_if.master     bus
);
    localparam int unsigned BLK_W = 4 * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_MERGE   = 2'd0,
        ST_DRAIN_A = 2'd1,
        ST_DRAIN_B = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t               state;
    logic                 first;
    logic [KEY_WIDTH-1:0] ka;
    logic [KEY_WIDTH-1:0] kb;
    logic                 a_wins_c;
    logic                 pick_a_c;
    logic                 pick_b_c;
    logic                 pick_flush_c;

    assign ka       = bus.i_a_elems[KEY_WIDTH-1:0];
    assign kb       = bus.i_b_elems[KEY_WIDTH-1:0];
    assign a_wins_c = (ka <= kb);

    // Issue decision for this cycle; a raised i_stall suppresses every selection.
    always_comb begin
        pick_a_c     = 1'b0;
        pick_b_c     = 1'b0;
        pick_flush_c = 1'b0;
        case (state)
            ST_MERGE: begin
                if (!bus.i_stall && !bus.i_a_empty && !bus.i_b_empty) begin
                    pick_a_c = a_wins_c;
                    pick_b_c = !a_wins_c;
                end
            end
            ST_DRAIN_A: pick_a_c     = !bus.i_stall && !bus.i_a_empty;
            ST_DRAIN_B: pick_b_c     = !bus.i_stall && !bus.i_b_empty;
            ST_FLUSH:   pick_flush_c = !bus.i_stall;
            default: begin
                pick_a_c     = 1'b0;
                pick_b_c     = 1'b0;
                pick_flush_c = 1'b0;
            end
        endcase
    end

    assign bus.o_a_rd = i_rst_n & pick_a_c;
    assign bus.o_b_rd = i_rst_n & pick_b_c;

    // State, first-of-pair flag and the registered network operand.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state               <= ST_MERGE;
            first               <= 1'b1;
            bus.o_elems         <= '0;
            bus.o_stall         <= 1'b1;
            bus.o_switch_output <= 1'b0;
            bus.o_last          <= 1'b0;
        end else begin
            bus.o_stall <= 1'b1;
            if (pick_a_c) begin
                bus.o_elems         <= bus.i_a_elems;
                bus.o_stall         <= 1'b0;
                bus.o_switch_output <= first;
                bus.o_last          <= 1'b0;
                first               <= 1'b0;
                if (bus.i_a_last) begin
                    state <= (state == ST_DRAIN_A) ? ST_FLUSH : ST_DRAIN_B;
                end
            end else if (pick_b_c) begin
                bus.o_elems         <= bus.i_b_elems;
                bus.o_stall         <= 1'b0;
                bus.o_switch_output <= first;
                bus.o_last          <= 1'b0;
                first               <= 1'b0;
                if (bus.i_b_last) begin
                    state <= (state == ST_DRAIN_B) ? ST_FLUSH : ST_DRAIN_A;
                end
            end else if (pick_flush_c) begin
                bus.o_elems         <= {BLK_W{1'b1}};
                bus.o_stall         <= 1'b0;
                bus.o_switch_output <= first;
                bus.o_last          <= 1'b1;
                first               <= 1'b1;
                state               <= ST_MERGE;
            end
        end
    end
endmodule
